bh_state_monitor: RTL and testbench

//  Downstream consumer of the ic1337 two-bit BH flip-flop pair. Samples {Q1,Q0}
//  and Z every enabled clock and produces registered status:
//   - saturating Z-high cycle count;
//   - Gray-cycle sequence detector (00->01->11->10) with wrapping hit count;
//   - stuck detector for an unchanged pair;
//   - sticky error when Z disagrees with Q0 XNOR Q1.
//  Its outputs feed the lab board LEDs and the self-check bench.
//

---
 rtl/bh_state_monitor.sv | 136 +++++++++++++
 tb/tb_bh_state_monitor.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bh_state_monitor.sv
// Status monitor for the ic1337 BH flip-flop pair: samples {q1,q0} and z on enabled cycles and
// keeps registered Z-high count, Gray-cycle hit count/pulse, stuck flag and sticky error.
module bh_state_monitor #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned HOLD_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             q0,
  input  logic             q1,
  input  logic             z,
  output logic [1:0]       last_pair,
  output logic [CNT_W-1:0] z_count,
  output logic [CNT_W-1:0] seq_count,
  output logic             seq_found,
  output logic             stuck,
  output logic             err
);

  localparam int unsigned    RunW   = $clog2(HOLD_LIMIT + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(HOLD_LIMIT);

  typedef enum logic [1:0] {
    StSeek,
    StGot00,
    StGot01,
    StGot11
  } seq_state_e;

  seq_state_e state_q, state_d;

  logic [1:0]       last_pair_q;
  logic             prev_valid_q;
  logic [RunW-1:0]  run_len_q, run_len_d;
  logic             stuck_q;
  logic [CNT_W-1:0] z_count_q, z_count_d;
  logic [CNT_W-1:0] seq_count_q, seq_count_d;
  logic             seq_found_q;
  logic             err_q, err_d;

  logic [1:0] pair;
  logic       change;
  logic       seq_hit;

  assign pair   = {q1, q0};
  // The very first sample after reset/clear always counts as a change.
  assign change = !prev_valid_q || (pair != last_pair_q);

  // ---------------------------------------------------------------------------
  // Sequence FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= StSeek;
    end else begin
      state_q <= state_d;
    end
  end

  // Sequence FSM: next state, advancing only on enabled change events
  always_comb begin
    state_d = state_q;
    if (en && change) begin
      unique case (state_q)
        StSeek:  state_d = (pair == 2'b00) ? StGot00 : StSeek;
        StGot00: state_d = (pair == 2'b01) ? StGot01 : StSeek;
        StGot01: begin
          if (pair == 2'b11)      state_d = StGot11;
          else if (pair == 2'b00) state_d = StGot00;
          else                    state_d = StSeek;
        end
        StGot11: state_d = (pair == 2'b00) ? StGot00 : StSeek;
        default: state_d = StSeek;
      endcase
    end
  end

  // Sequence FSM: completion decode
  always_comb begin
    seq_hit = en && change && (state_q == StGot11) && (pair == 2'b10);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state values
  // ---------------------------------------------------------------------------
  always_comb begin
    run_len_d = run_len_q;
    if (change) begin
      run_len_d = RunW'(1);
    end else if (run_len_q != RunMax) begin
      run_len_d = run_len_q + RunW'(1);
    end

    z_count_d = z_count_q;
    if (z && (z_count_q != {CNT_W{1'b1}})) begin
      z_count_d = z_count_q + CNT_W'(1);
    end

    seq_count_d = seq_hit ? seq_count_q + CNT_W'(1) : seq_count_q;
    err_d       = err_q | (z != (q0 ~^ q1));
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      last_pair_q  <= 2'b00;
      prev_valid_q <= 1'b0;
      run_len_q    <= '0;
      stuck_q      <= 1'b0;
      z_count_q    <= '0;
      seq_count_q  <= '0;
      seq_found_q  <= 1'b0;
      err_q        <= 1'b0;
    end else if (en) begin
      last_pair_q  <= pair;
      prev_valid_q <= 1'b1;
      run_len_q    <= run_len_d;
      stuck_q      <= (run_len_d == RunMax);
      z_count_q    <= z_count_d;
      seq_count_q  <= seq_count_d;
      seq_found_q  <= seq_hit;
      err_q        <= err_d;
    end else begin
      seq_found_q  <= 1'b0;
    end
  end

  assign last_pair = last_pair_q;
  assign z_count   = z_count_q;
  assign seq_count = seq_count_q;
  assign seq_found = seq_found_q;
  assign stuck     = stuck_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bh_state_monitor.sv
// Directed self-checking bench for bh_state_monitor (CNT_W=8, HOLD_LIMIT=4).
module tb_bh_state_monitor;

  logic       clk = 1'b0;
  logic       rst, en, clr, q0, q1, z;
  logic [1:0] last_pair;
  logic [7:0] z_count, seq_count;
  logic       seq_found, stuck, err;

  int checks = 0;
  int errors = 0;

  bh_state_monitor #(
    .CNT_W      (8),
    .HOLD_LIMIT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .q0        (q0),
    .q1        (q1),
    .z         (z),
    .last_pair (last_pair),
    .z_count   (z_count),
    .seq_count (seq_count),
    .seq_found (seq_found),
    .stuck     (stuck),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Enabled sample with an explicit z value.
  task automatic sample(input logic [1:0] p, input logic zz);
    en = 1'b1; clr = 1'b0; rst = 1'b0;
    q1 = p[1]; q0 = p[0]; z = zz;
    tick();
  endtask

  // Enabled sample with z consistent with the pair (z = q0 xnor q1).
  task automatic gray(input logic [1:0] p);
    sample(p, ~(p[1] ^ p[0]));
  endtask

  task automatic idle(input logic [1:0] p, input logic zz);
    en = 1'b0; clr = 1'b0; rst = 1'b0;
    q1 = p[1]; q0 = p[0]; z = zz;
    tick();
  endtask

  task automatic do_clr();
    en = 1'b1; clr = 1'b1; rst = 1'b0;
    q1 = 1'b1; q0 = 1'b1; z = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; q0 = 1'b0; q1 = 1'b0; z = 1'b0;

    // Reset with random activity on the inputs
    for (int i = 0; i < 2; i++) begin
      en = 1'(($urandom) & 1); q0 = 1'(($urandom) & 1); q1 = 1'(($urandom) & 1);
      z  = 1'(($urandom) & 1);
      tick();
    end
    check("rst last_pair", 32'(last_pair), 0);
    check("rst z_count",   32'(z_count),   0);
    check("rst seq_count", 32'(seq_count), 0);
    check("rst seq_found", 32'(seq_found), 0);
    check("rst stuck",     32'(stuck),     0);
    check("rst err",       32'(err),       0);

    // Single clean Gray cycle
    gray(2'b00); check("g1 found0", 32'(seq_found), 0);
    gray(2'b01); check("g1 found1", 32'(seq_found), 0);
    gray(2'b11); check("g1 found2", 32'(seq_found), 0);
    gray(2'b10);
    check("g1 found",     32'(seq_found), 1);
    check("g1 seq_count", 32'(seq_count), 1);
    check("g1 z_count",   32'(z_count),   2);
    check("g1 last_pair", 32'(last_pair), 2);
    check("g1 err",       32'(err),       0);
    check("g1 stuck",     32'(stuck),     0);
    gray(2'b10);
    check("g1 repeat no pulse", 32'(seq_found), 0);
    check("g1 repeat count",    32'(seq_count), 1);

    // Repeats ignored by the FSM; broken sequence returns to seek
    do_clr();
    gray(2'b00); gray(2'b00); gray(2'b01); gray(2'b01); gray(2'b11); gray(2'b10);
    check("rep found", 32'(seq_found), 1);
    check("rep count", 32'(seq_count), 1);
    gray(2'b00); gray(2'b01); gray(2'b10);
    check("brk found", 32'(seq_found), 0);
    gray(2'b11); gray(2'b10);
    check("brk count", 32'(seq_count), 1);
    check("brk found2", 32'(seq_found), 0);

    // Stuck detection on a held pair
    do_clr();
    for (int i = 0; i < 6; i++) begin
      gray(2'b11);
      check($sformatf("stuck s%0d", i), 32'(stuck), (i >= 3) ? 1 : 0);
    end
    check("stuck z_count", 32'(z_count), 6);
    gray(2'b00);
    check("stuck drop", 32'(stuck), 0);

    // Saturating z_count
    do_clr();
    for (int i = 0; i < 300; i++) sample(2'b00, 1'b1);
    check("sat z_count", 32'(z_count), 255);
    check("sat stuck",   32'(stuck),   1);
    check("sat err",     32'(err),     0);

    // Wrapping seq_count
    do_clr();
    for (int i = 0; i < 257; i++) begin
      gray(2'b00); gray(2'b01); gray(2'b11); gray(2'b10);
    end
    check("wrap seq_count", 32'(seq_count), 1);
    check("wrap found",     32'(seq_found), 1);
    check("wrap z_count",   32'(z_count),   255);

    // Sticky error, hold while disabled, then clear
    do_clr();
    sample(2'b01, 1'b1);
    check("err set",     32'(err),     1);
    check("err z_count", 32'(z_count), 1);
    for (int i = 0; i < 3; i++) idle(2'b10, 1'b0);
    check("hold err",       32'(err),       1);
    check("hold last_pair", 32'(last_pair), 1);
    check("hold z_count",   32'(z_count),   1);
    check("hold found",     32'(seq_found), 0);
    sample(2'b00, 1'b1);
    check("err sticky", 32'(err), 1);
    en = 1'b1; clr = 1'b1; q1 = 1'b1; q0 = 1'b1; z = 1'b1;
    tick();
    clr = 1'b0;
    check("clr err",       32'(err),       0);
    check("clr z_count",   32'(z_count),   0);
    check("clr last_pair", 32'(last_pair), 0);
    check("clr stuck",     32'(stuck),     0);

    // Partial progress is abandoned by clr and by rst
    gray(2'b00); gray(2'b01); gray(2'b11);
    do_clr();
    gray(2'b10);
    check("abandon clr found", 32'(seq_found), 0);
    gray(2'b00); gray(2'b01); gray(2'b11);
    rst = 1'b1; en = 1'b1; tick(); rst = 1'b0;
    gray(2'b10);
    check("abandon rst found", 32'(seq_found), 0);
    check("abandon count",     32'(seq_count), 0);

    // First sample after clr is a change event even if it matches the cleared pair
    do_clr();
    gray(2'b00); gray(2'b01); gray(2'b11); gray(2'b10);
    check("post clr found", 32'(seq_found), 1);
    check("post clr count", 32'(seq_count), 1);

    // rst dominates clr and en
    rst = 1'b1; clr = 1'b1; en = 1'b1; q1 = 1'b0; q0 = 1'b1; z = 1'b1;
    tick();
    rst = 1'b0; clr = 1'b0;
    check("prio count", 32'(seq_count), 0);
    check("prio last",  32'(last_pair), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
